// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller.
//   phase_e : phase codes as seen on the phase output
//   RED/YEL/GRN/OFF : {R,Y,G} lamp encodings
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR1   = 3'd2,
      EW_G  = 3'd3,
      EW_Y  = 3'd4,
      AR2   = 3'd5,
      FLASH = 3'd6
   } phase_e;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// Loadable down-counter advanced by a tick enable; saturates at zero.
//   load/load_val : synchronous load, has priority over counting
//   tick_en       : decrement by one when count is non-zero
//   count / last  : current value, and count==1 flag
module phase_timer #(
   parameter int               CNT_W   = 5,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick_en,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick_en && count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= RST_VAL;
      else      count_q <= count_d;
   end

   assign count = count_q;
   assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer driven by a 1 s tick.
//   clk, rst (async, active-low), tick_1s, en
//   ped_req_ns/ew : pedestrian requests, latched until the matching green
//   night_mode    : flashing-yellow operation, entered at all-red expiry
//   lights_ns/ew, ped_walk_ns/ew, remaining, phase : registered outputs
//
// state | meaning
// NS_G  | NS green, EW red; NS walk window at start
// NS_Y  | NS yellow
// AR1   | all red before EW green (or NS green after FLASH)
// EW_G  | EW green, NS red; EW walk window at start
// EW_Y  | EW yellow
// AR2   | all red before NS green; reset state
// FLASH | night mode, both directions flash yellow
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int T_GREEN  = 10,
   parameter int T_YELLOW = 3,
   parameter int T_ALLRED = 2,
   parameter int T_PED    = 8,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1s,
   input  logic             en,
   input  logic             ped_req_ns,
   input  logic             ped_req_ew,
   input  logic             night_mode,
   output logic [2:0]       lights_ns,
   output logic [2:0]       lights_ew,
   output logic             ped_walk_ns,
   output logic             ped_walk_ew,
   output logic [CNT_W-1:0] remaining,
   output logic [2:0]       phase
);

   function automatic logic [CNT_W-1:0] dur(input phase_e p);
      case (p)
         NS_G, EW_G: return CNT_W'(T_GREEN);
         NS_Y, EW_Y: return CNT_W'(T_YELLOW);
         AR1, AR2:   return CNT_W'(T_ALLRED);
         default:    return '0;
      endcase
   endfunction

   phase_e           phase_q, phase_d;
   logic             flash_q, flash_d;
   logic             after_flash_q, after_flash_d;
   logic             latch_ns_q, latch_ns_d, latch_ew_q, latch_ew_d;
   logic             walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
   logic [2:0]       lights_ns_q, lights_ns_d, lights_ew_q, lights_ew_d;

   logic             adv;
   logic             ph_load, ph_last;
   logic [CNT_W-1:0] ph_load_val, ph_cnt;
   logic             wk_last;
   logic [CNT_W-1:0] wk_cnt;
   logic             enter_ns, enter_ew, walk_hold;

   assign adv = tick_1s & en;

   phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(T_ALLRED))) u_phase_tmr (
      .clk(clk), .rst(rst), .load(ph_load), .load_val(ph_load_val),
      .tick_en(adv), .count(ph_cnt), .last(ph_last)
   );

   // One walk timer serves both crossings: only one green exists at a time.
   phase_timer #(.CNT_W(CNT_W), .RST_VAL('0)) u_walk_tmr (
      .clk(clk), .rst(rst), .load(enter_ns | enter_ew), .load_val(CNT_W'(T_PED)),
      .tick_en(adv), .count(wk_cnt), .last(wk_last)
   );

   always_comb begin
      phase_d       = phase_q;
      flash_d       = flash_q;
      after_flash_d = after_flash_q;
      ph_load       = 1'b0;
      ph_load_val   = '0;
      if (adv) begin
         if (phase_q == FLASH) begin
            if (night_mode) begin
               flash_d = ~flash_q;
            end else begin
               phase_d       = AR1;
               flash_d       = 1'b0;
               after_flash_d = 1'b1;
               ph_load       = 1'b1;
               ph_load_val   = dur(AR1);
            end
         end else if (ph_last) begin
            ph_load = 1'b1;
            unique case (phase_q)
               NS_G: phase_d = NS_Y;
               NS_Y: phase_d = AR1;
               AR1: begin
                  // Leaving FLASH resumes with NS green rather than EW.
                  phase_d       = after_flash_q ? NS_G : EW_G;
                  after_flash_d = 1'b0;
               end
               EW_G: phase_d = EW_Y;
               EW_Y: phase_d = AR2;
               AR2:  phase_d = NS_G;
               default: phase_d = AR2;
            endcase
            if ((phase_q == AR1 || phase_q == AR2) && night_mode) begin
               phase_d = FLASH;
               flash_d = 1'b1;
            end
            ph_load_val = dur(phase_d);
         end
      end
   end

   always_comb begin
      enter_ns  = (phase_d == NS_G) && (phase_q != NS_G);
      enter_ew  = (phase_d == EW_G) && (phase_q != EW_G);
      walk_hold = (wk_cnt != '0) && !(adv && wk_last);

      latch_ns_d = enter_ns ? 1'b0 : (latch_ns_q | ped_req_ns);
      latch_ew_d = enter_ew ? 1'b0 : (latch_ew_q | ped_req_ew);

      walk_ns_d = 1'b0;
      if (enter_ns)              walk_ns_d = latch_ns_q | ped_req_ns;
      else if (phase_d == NS_G)  walk_ns_d = walk_ns_q & walk_hold;

      walk_ew_d = 1'b0;
      if (enter_ew)              walk_ew_d = latch_ew_q | ped_req_ew;
      else if (phase_d == EW_G)  walk_ew_d = walk_ew_q & walk_hold;

      lights_ns_d = RED;
      lights_ew_d = RED;
      case (phase_d)
         NS_G:  lights_ns_d = GRN;
         NS_Y:  lights_ns_d = YEL;
         EW_G:  lights_ew_d = GRN;
         EW_Y:  lights_ew_d = YEL;
         FLASH: begin
            lights_ns_d = flash_d ? YEL : OFF;
            lights_ew_d = flash_d ? YEL : OFF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q       <= AR2;
         flash_q       <= 1'b0;
         after_flash_q <= 1'b0;
         latch_ns_q    <= 1'b0;
         latch_ew_q    <= 1'b0;
         walk_ns_q     <= 1'b0;
         walk_ew_q     <= 1'b0;
         lights_ns_q   <= RED;
         lights_ew_q   <= RED;
      end else begin
         phase_q       <= phase_d;
         flash_q       <= flash_d;
         after_flash_q <= after_flash_d;
         latch_ns_q    <= latch_ns_d;
         latch_ew_q    <= latch_ew_d;
         walk_ns_q     <= walk_ns_d;
         walk_ew_q     <= walk_ew_d;
         lights_ns_q   <= lights_ns_d;
         lights_ew_q   <= lights_ew_d;
      end
   end

   assign lights_ns   = lights_ns_q;
   assign lights_ew   = lights_ew_q;
   assign ped_walk_ns = walk_ns_q;
   assign ped_walk_ew = walk_ew_q;
   assign remaining   = ph_cnt;
   assign phase       = phase_q;

   a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
      (phase_q != FLASH) |-> (lights_ns_q == RED || lights_ew_q == RED));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

   localparam logic [2:0] P_NSG = 3'd0, P_NSY = 3'd1, P_AR1 = 3'd2, P_EWG = 3'd3,
                          P_EWY = 3'd4, P_AR2 = 3'd5, P_FL = 3'd6;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1s = 1'b0, en = 1'b0;
   logic       ped_req_ns = 1'b0, ped_req_ew = 1'b0, night_mode = 1'b0;
   logic [2:0] lights_ns, lights_ew;
   logic       ped_walk_ns, ped_walk_ew;
   logic [4:0] remaining;
   logic [2:0] phase;

   int n_run = 0, n_fail = 0;

   traffic_phase_ctrl dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s), .en(en),
      .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew), .night_mode(night_mode),
      .lights_ns(lights_ns), .lights_ew(lights_ew),
      .ped_walk_ns(ped_walk_ns), .ped_walk_ew(ped_walk_ew),
      .remaining(remaining), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pns, pew, en, night;
      logic [7:0] n;
      logic [2:0] ph;
      logic [4:0] rem;
      logic [2:0] ns, ew;
      logic       wns, wew;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic pns, pew, e, nt, input int n,
                               input logic [2:0] ph, input int rem,
                               input logic [2:0] ns, ew, input logic wns, wew);
      vec_t v;
      v.pns = pns; v.pew = pew; v.en = e; v.night = nt; v.n = 8'(n);
      v.ph = ph; v.rem = 5'(rem); v.ns = ns; v.ew = ew; v.wns = wns; v.wew = wew;
      return v;
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tick_1s = 1'b1;
         @(negedge clk);
         tick_1s = 1'b0;
         idle(3);
      end
   endtask

   task automatic chk(input string name, input logic [2:0] ph, input int rem,
                      input logic [2:0] ns, ew, input logic wns, wew);
      logic [15:0] got, exp;
      got = {phase, remaining, lights_ns, lights_ew, ped_walk_ns, ped_walk_ew};
      exp = {ph, 5'(rem), ns, ew, wns, wew};
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got ph=%0d rem=%0d ns=%b ew=%b wns=%b wew=%b, exp ph=%0d rem=%0d ns=%b ew=%b wns=%b wew=%b",
                  name, phase, remaining, lights_ns, lights_ew, ped_walk_ns, ped_walk_ew,
                  ph, rem, ns, ew, wns, wew);
      end
   endtask

   initial begin
      //                 pns pew en nt  n   phase  rem ns ew wns wew
      vecs.push_back(mk(0, 0, 1, 0,  1, P_AR2,  1, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_NSG, 10, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  9, P_NSG,  1, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_NSY,  3, Y, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  3, P_AR1,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_EWG, 10, R, G, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0,  1, P_EWG,  9, R, G, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_EWG,  8, R, G, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0,  1, P_EWG,  7, R, G, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  7, P_EWY,  3, R, Y, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  3, P_AR2,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_NSG, 10, G, R, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0,  7, P_NSG,  3, G, R, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_NSG,  2, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_NSY,  3, Y, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  3, P_AR1,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_EWG, 10, R, G, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0,  7, P_EWG,  3, R, G, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_EWG,  2, R, G, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_EWY,  3, R, Y, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  3, P_AR2,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_NSG, 10, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  4, P_NSG,  6, G, R, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 20, P_NSG,  6, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  5, P_NSG,  1, G, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_NSY,  3, Y, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  3, P_AR1,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_EWG, 10, R, G, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_EWG,  9, R, G, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1,  8, P_EWG,  1, R, G, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_EWY,  3, R, Y, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  3, P_AR2,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_AR2,  1, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_FL,   0, Y, Y, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_FL,   0, O, O, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1,  1, P_FL,   0, Y, Y, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  1, P_AR1,  2, R, R, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0,  2, P_NSG, 10, G, R, 0, 0));

      idle(3);
      chk("reset_state", P_AR2, 2, R, R, 0, 0);
      rst = 1'b1;
      en  = 1'b1;
      idle(2);

      for (int i = 0; i < vecs.size(); i++) begin
         en         = vecs[i].en;
         night_mode = vecs[i].night;
         if (vecs[i].pns || vecs[i].pew) begin
            ped_req_ns = vecs[i].pns;
            ped_req_ew = vecs[i].pew;
            @(negedge clk);
            ped_req_ns = 1'b0;
            ped_req_ew = 1'b0;
            idle(1);
         end
         ticks(int'(vecs[i].n));
         chk($sformatf("vec[%0d]", i), vecs[i].ph, int'(vecs[i].rem),
             vecs[i].ns, vecs[i].ew, vecs[i].wns, vecs[i].wew);
      end

      // Request coincident with the NS green exit edge is kept for the next NS green.
      ticks(9);
      chk("nsg_last_tick", P_NSG, 1, G, R, 0, 0);
      tick_1s = 1'b1; ped_req_ns = 1'b1;
      @(negedge clk);
      tick_1s = 1'b0; ped_req_ns = 1'b0;
      idle(3);
      chk("exit_edge_nsy", P_NSY, 3, Y, R, 0, 0);
      ticks(20);
      chk("exit_edge_req_held", P_NSG, 10, G, R, 1, 0);

      // Reset mid EW_Y with an NS request latched.
      ticks(15);
      chk("pre_rst_ewg", P_EWG, 10, R, G, 0, 0);
      ped_req_ns = 1'b1;
      @(negedge clk);
      ped_req_ns = 1'b0;
      ticks(11);
      chk("pre_rst_ewy", P_EWY, 2, R, Y, 0, 0);
      #2 rst = 1'b0;
      #1 chk("rst_async", P_AR2, 2, R, R, 0, 0);
      @(negedge clk);
      tick_1s = 1'b1;
      idle(2);
      tick_1s = 1'b0;
      chk("rst_dominates_tick", P_AR2, 2, R, R, 0, 0);
      rst = 1'b1;
      idle(2);
      ticks(1);
      chk("post_rst_ar2", P_AR2, 1, R, R, 0, 0);
      ticks(1);
      chk("post_rst_no_walk", P_NSG, 10, G, R, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
